// File: rtl/matrix_fb_if.sv
// Pixel-write, scan-read and buffer-control signals between game logic / scan driver
// (master) and the matrix_fb frame buffer (slave).
interface matrix_fb_if #(
  parameter int COL_W = 6,
  parameter int ROW_W = 4
);
  logic             wr_en;
  logic [COL_W-1:0] wr_x;
  logic [ROW_W:0]   wr_y;
  logic [2:0]       wr_rgb;
  logic             wr_ready;
  logic             rd_en;
  logic [ROW_W-1:0] rd_row;
  logic [COL_W-1:0] rd_col;
  logic             rd_valid;
  logic [2:0]       rd_rgb0;
  logic [2:0]       rd_rgb1;
  logic             frame_end;
  logic             swap_req;
  logic             swap_done;
  logic             clear_req;
  logic             clr_busy;

  modport master (
    output wr_en, wr_x, wr_y, wr_rgb, rd_en, rd_row, rd_col,
           frame_end, swap_req, clear_req,
    input  wr_ready, rd_valid, rd_rgb0, rd_rgb1, swap_done, clr_busy
  );

  modport slave (
    input  wr_en, wr_x, wr_y, wr_rgb, rd_en, rd_row, rd_col,
           frame_end, swap_req, clear_req,
    output wr_ready, rd_valid, rd_rgb0, rd_rgb1, swap_done, clr_busy
  );
endinterface

// File: rtl/matrix_fb.sv
// Double-buffered HUB75 frame buffer: pixel writes go to the back bank, the scan driver
// reads front-bank half-row pairs, swaps happen on frame_end. MATRIX_FB_CLEAR_EN builds the clear engine.
module matrix_fb #(
  parameter int COL_W = 6,
  parameter int ROW_W = 4
) (
  input  logic        clk,
  input  logic        rst,
  matrix_fb_if.slave  bus
);
  localparam int AW    = COL_W + ROW_W;
  localparam int DEPTH = 1 << AW;

  // Bank select is the MSB of the memory index: {bank, row, col}.
  logic [2:0] mem_up [2*DEPTH];
  logic [2:0] mem_lo [2*DEPTH];

  logic          front;
  logic          swap_pending;
  logic          swap_fire;
  logic          done_p1;
  logic          clr_busy;
  logic          clr_we;
  logic [AW-1:0] clr_addr;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr;
  logic          wr_fire;
  logic          vld_p1;
  logic [2:0]    rgb0_p1;
  logic [2:0]    rgb1_p1;

  assign wr_addr   = {bus.wr_y[ROW_W-1:0], bus.wr_x};
  assign rd_addr   = {bus.rd_row, bus.rd_col};
  assign wr_fire   = bus.wr_en && !clr_busy;
  assign swap_fire = bus.frame_end && (swap_pending || bus.swap_req) && !clr_busy;

`ifdef MATRIX_FB_CLEAR_EN
  typedef enum logic {IDLE, CLEAR} clr_state_t;
  clr_state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      clr_busy <= 1'b0;
      clr_addr <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.clear_req) begin
            state    <= CLEAR;
            clr_busy <= 1'b1;
            clr_addr <= '0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (&clr_addr) begin
            state    <= IDLE;
            clr_busy <= 1'b0;
          end
        end
      endcase
    end
  end

  assign clr_we = clr_busy;
`else
  assign clr_busy = 1'b0;
  assign clr_we   = 1'b0;
  assign clr_addr = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      front        <= 1'b0;
      swap_pending <= 1'b0;
      done_p1      <= 1'b0;
    end else begin
      done_p1 <= swap_fire;
      if (swap_fire) begin
        front        <= ~front;
        swap_pending <= 1'b0;
      end else if (bus.swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Stage p0 -> memory: writes always target the bank that is back before this edge.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_up[{~front, clr_addr}] <= '0;
      mem_lo[{~front, clr_addr}] <= '0;
    end else if (wr_fire) begin
      if (bus.wr_y[ROW_W]) mem_lo[{~front, wr_addr}] <= bus.wr_rgb;
      else                 mem_up[{~front, wr_addr}] <= bus.wr_rgb;
    end
  end

  // Stage p0 -> p1: read both halves of the front bank; data holds when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      rgb0_p1 <= '0;
      rgb1_p1 <= '0;
    end else begin
      vld_p1 <= bus.rd_en;
      if (bus.rd_en) begin
        rgb0_p1 <= mem_up[{front, rd_addr}];
        rgb1_p1 <= mem_lo[{front, rd_addr}];
      end
    end
  end

  assign bus.rd_valid  = vld_p1;
  assign bus.rd_rgb0   = rgb0_p1;
  assign bus.rd_rgb1   = rgb1_p1;
  assign bus.swap_done = done_p1;
  assign bus.clr_busy  = clr_busy;
  assign bus.wr_ready  = !clr_busy;
endmodule

// File: tb/tb_matrix_fb.sv
// Directed bench for matrix_fb: a bank/pixel-level model checks every cycle, plus
// hand-computed literal reads that pin the model.
module tb_matrix_fb;
  localparam int COL_W = 6;
  localparam int ROW_W = 4;
  localparam int NADDR = 1 << (COL_W + ROW_W);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  matrix_fb_if #(.COL_W(COL_W), .ROW_W(ROW_W)) bus ();

  matrix_fb #(.COL_W(COL_W), .ROW_W(ROW_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;
  int sd_count = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [2:0] m_up [2][NADDR];
  logic [2:0] m_lo [2][NADDR];
  int         m_front = 0;
  bit         m_pend = 0;
  int         m_clr_left = 0;
  int         m_clr_idx = 0;
  logic       e_valid = 1'b0;
  logic [2:0] e_rgb0 = 3'b000;
  logic [2:0] e_rgb1 = 3'b000;
  logic       e_done = 1'b0;
  logic       e_busy = 1'b0;

  always @(posedge clk) begin
    int  a;
    bit  busy;
    bit  fire;
    if (rst) begin
      m_front = 0; m_pend = 0; m_clr_left = 0;
      e_valid = 1'b0; e_rgb0 = 3'b000; e_rgb1 = 3'b000; e_done = 1'b0;
    end else begin
      busy = (m_clr_left > 0);
      e_valid = bus.rd_en;
      if (bus.rd_en) begin
        a = int'(bus.rd_row) * 64 + int'(bus.rd_col);
        e_rgb0 = m_up[m_front][a];
        e_rgb1 = m_lo[m_front][a];
      end
      if (busy) begin
        m_up[1-m_front][m_clr_idx] = 3'b000;
        m_lo[1-m_front][m_clr_idx] = 3'b000;
        m_clr_idx++;
        m_clr_left--;
      end else if (bus.wr_en) begin
        a = int'(bus.wr_y % 16) * 64 + int'(bus.wr_x);
        if (bus.wr_y >= 16) m_lo[1-m_front][a] = bus.wr_rgb;
        else                m_up[1-m_front][a] = bus.wr_rgb;
      end
      fire = bus.frame_end && (m_pend || bus.swap_req) && !busy;
      e_done = fire;
      if (fire) begin
        m_front = 1 - m_front;
        m_pend = 0;
      end else if (bus.swap_req) begin
        m_pend = 1;
      end
`ifdef MATRIX_FB_CLEAR_EN
      if (!busy && bus.clear_req) begin
        m_clr_left = NADDR;
        m_clr_idx = 0;
      end
`endif
    end
    e_busy = (m_clr_left > 0);
    #1;
    chk("rd_valid", bus.rd_valid, e_valid);
    chk("swap_done", bus.swap_done, e_done);
    chk("clr_busy", bus.clr_busy, e_busy);
    chk("wr_ready", bus.wr_ready, !e_busy);
    if (!$isunknown(e_rgb0)) chk("rd_rgb0", bus.rd_rgb0, e_rgb0);
    if (!$isunknown(e_rgb1)) chk("rd_rgb1", bus.rd_rgb1, e_rgb1);
    if (bus.swap_done === 1'b1) sd_count++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic write_px(input int x, input int y, input logic [2:0] rgb);
    bus.wr_en = 1'b1; bus.wr_x = 6'(x); bus.wr_y = 5'(y); bus.wr_rgb = rgb;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic pulse_swap();
    bus.swap_req = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0;
  endtask

  task automatic pulse_frame();
    bus.frame_end = 1'b1;
    @(negedge clk);
    bus.frame_end = 1'b0;
  endtask

  task automatic read_lit(input string nm, input int row, input int col,
                          input logic [2:0] e0, input logic [2:0] e1);
    bus.rd_en = 1'b1; bus.rd_row = 4'(row); bus.rd_col = 6'(col);
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk({nm, "_valid"}, bus.rd_valid, 1'b1);
    chk({nm, "_rgb0"}, bus.rd_rgb0, e0);
    chk({nm, "_rgb1"}, bus.rd_rgb1, e1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sd0;
    int cnt;
    bus.wr_en = 0; bus.wr_x = '0; bus.wr_y = '0; bus.wr_rgb = '0;
    bus.rd_en = 0; bus.rd_row = '0; bus.rd_col = '0;
    bus.frame_end = 0; bus.swap_req = 0; bus.clear_req = 0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_wr_ready", bus.wr_ready, 1'b1);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rgb0", bus.rd_rgb0, 3'b000);
    chk("rst_rgb1", bus.rd_rgb1, 3'b000);
    chk("rst_swap_done", bus.swap_done, 1'b0);
    chk("rst_clr_busy", bus.clr_busy, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    chk("idle_rd_valid", bus.rd_valid, 1'b0);
    bus.rd_en = 1'b1;
    @(negedge clk);
    bus.rd_en = 1'b0;
    chk("first_read_valid", bus.rd_valid, 1'b1);
    @(negedge clk);
    chk("valid_drops", bus.rd_valid, 1'b0);

    // Basic write, swap, read (front 0 -> 1)
    write_px(5, 3, 3'b100);
    write_px(5, 19, 3'b010);
    pulse_swap();
    pulse_frame();
    chk("swap_done_after_frame", bus.swap_done, 1'b1);
    read_lit("rd_3_5", 3, 5, 3'b100, 3'b010);

    // Pending swap without frame_end (front 1 -> 0 only after frame_end)
    write_px(5, 3, 3'b011);
    write_px(5, 19, 3'b101);
    sd0 = sd_count;
    pulse_swap();
    repeat (100) @(negedge clk);
    read_lit("old_data", 3, 5, 3'b100, 3'b010);
    chk("no_swap_without_frame", sd_count - sd0, 0);
    pulse_frame();
    repeat (5) @(negedge clk);
    chk("single_swap_done", sd_count - sd0, 1);
    read_lit("new_data", 3, 5, 3'b011, 3'b101);

    // Write in the swap cycle lands in the bank that becomes front (front 0 -> 1)
    write_px(10, 4, 3'b110);
    pulse_swap();
    bus.frame_end = 1'b1;
    bus.wr_en = 1'b1; bus.wr_x = 6'd10; bus.wr_y = 5'd20; bus.wr_rgb = 3'b111;
    @(negedge clk);
    bus.frame_end = 1'b0; bus.wr_en = 1'b0;
    read_lit("swap_edge_write", 4, 10, 3'b110, 3'b111);

    // Address corners, swap_req and frame_end together (front 1 -> 0)
    write_px(63, 31, 3'b001);
    write_px(0, 0, 3'b110);
    write_px(63, 15, 3'b010);
    write_px(0, 16, 3'b101);
    bus.swap_req = 1'b1; bus.frame_end = 1'b1;
    @(negedge clk);
    bus.swap_req = 1'b0; bus.frame_end = 1'b0;
    read_lit("corner_hi", 15, 63, 3'b010, 3'b001);
    read_lit("corner_lo", 0, 0, 3'b110, 3'b101);
    for (int r = 0; r < 16; r++) begin
      bus.rd_en = 1'b1; bus.rd_row = 4'(r); bus.rd_col = 6'd63;
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);

    // Reset while bank 1 is front returns display to bank 0
    pulse_swap();
    pulse_frame();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    read_lit("after_reset_front0", 0, 0, 3'b110, 3'b101);

`ifdef MATRIX_FB_CLEAR_EN
    // Fill back bank (bank 1) with white, then clear it
    for (int y = 0; y < 32; y++)
      for (int x = 0; x < 64; x++) begin
        bus.wr_en = 1'b1; bus.wr_x = 6'(x); bus.wr_y = 5'(y); bus.wr_rgb = 3'b111;
        @(negedge clk);
      end
    bus.wr_en = 1'b0;
    bus.clear_req = 1'b1;
    @(negedge clk);
    bus.clear_req = 1'b0;
    sd0 = sd_count;
    cnt = 0;
    while (bus.clr_busy === 1'b1 && cnt < 2000) begin
      cnt++;
      bus.wr_en = (cnt == 100);
      bus.wr_x = 6'd1; bus.wr_y = 5'd1; bus.wr_rgb = 3'b111;
      bus.swap_req = (cnt == 200);
      bus.frame_end = (cnt == 200);
      bus.clear_req = (cnt == 300);
      @(negedge clk);
    end
    bus.wr_en = 0; bus.swap_req = 0; bus.frame_end = 0; bus.clear_req = 0;
    chk("clear_busy_cycles", cnt, 1024);
    chk("no_swap_during_clear", sd_count - sd0, 0);
    pulse_frame();
    chk("swap_after_clear", bus.swap_done, 1'b1);
    read_lit("cleared_dropped_write", 1, 1, 3'b000, 3'b000);
    for (int a = 0; a < NADDR; a++) begin
      bus.rd_en = 1'b1; bus.rd_row = 4'(a / 64); bus.rd_col = 6'(a % 64);
      @(negedge clk);
    end
    bus.rd_en = 1'b0;
    @(negedge clk);
    read_lit("cleared_corner", 15, 63, 3'b000, 3'b000);
`endif

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/matrix_fb.md
# matrix_fb

Double-buffered frame buffer for the 64×32 HUB75 LED panel, sitting directly upstream of the row-scan driver. Game logic draws single pixels into the back buffer while the scan driver reads the front buffer as upper/lower half-row pixel pairs. A requested buffer swap is applied only at a frame boundary reported by the scan driver, so the panel never shows a partially drawn frame. An optional engine clears the back buffer in hardware.

## Interface
Parameters:
- COL_W, 6, column address width; the panel has 2^COL_W = 64 columns.
- ROW_W, 4, half-row address width; the panel has 2^(ROW_W+1) = 32 rows.

Ports (clock and reset: one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic acts on its rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  pixel write strobe for the back buffer.
- wr_x  in  COL_W  write column.
- wr_y  in  ROW_W+1  write row; MSB selects the lower panel half.
- wr_rgb  in  3  write colour {R,G,B}.
- wr_ready  out  1  writes accepted; low while a clear is running.
- rd_en  in  1  read strobe from the scan driver.
- rd_row  in  ROW_W  half-row address.
- rd_col  in  COL_W  column address.
- rd_valid  out  1  read data valid.
- rd_rgb0  out  3  {R0,G0,B0}: upper-half pixel at (rd_row, rd_col).
- rd_rgb1  out  3  {R1,G1,B1}: lower-half pixel at (rd_row+16, rd_col).
- frame_end  in  1  one-cycle pulse from the scan driver after its last row is latched.
- swap_req  in  1  one-cycle pulse from game logic: back buffer is complete.
- swap_done  out  1  one-cycle pulse: the swap has taken effect.
- clear_req  in  1  one-cycle pulse: start clearing the back buffer.
- clr_busy  out  1  clear in progress.

## Operation
- Storage: two banks. Each bank is split into upper and lower halves of 2^(COL_W+ROW_W) = 1024 × 3 bits each. Address = {row, col}. The memory is not reset.
- `front` register: 0 means bank 0 is displayed. The back bank is always !front.
- Write: wr_en && wr_ready stores wr_rgb in the back bank, half wr_y[ROW_W], at address {wr_y[ROW_W-1:0], wr_x]. The bank is taken from `front` before the clock edge. A write in the same cycle as a swap therefore lands in the bank that becomes front. wr_en while !wr_ready is dropped.
- Read: rd_en reads both halves of the front bank at {rd_row, rd_col}. The bank is taken from `front` in the request cycle.
- Swap control:
  - swap_pending is set by swap_req.
  - The swap executes in a cycle where frame_end = 1, (swap_pending || swap_req), and clr_busy = 0.
  - On the swap: `front` toggles, swap_pending clears, and swap_done pulses on the next cycle.
  - frame_end without a pending request does nothing.
  - Repeated swap_req before a swap collapses into a single swap.
  - A swap blocked by clr_busy stays pending until the first frame_end after the clear finishes.
- Clear FSM, states IDLE and CLEAR:
  - IDLE → CLEAR on clear_req. clr_addr is loaded with 0.
  - In CLEAR, each cycle writes 0 to both halves of the back bank at clr_addr, then increments clr_addr.
  - CLEAR → IDLE after the write at address 1023 (all ones).
  - clear_req while in CLEAR is ignored.
  - wr_ready = !clr_busy.
- Reset mid-operation: the FSM returns to IDLE, front = 0, swap_pending = 0. Memory keeps whatever it held, so a partially cleared bank stays partial.

## Timing
- Reset values: wr_ready = 1, rd_valid = 0, rd_rgb0 = rd_rgb1 = 0, swap_done = 0, clr_busy = 0, front = 0.
- Read latency is 1 cycle. rd_en in cycle N gives rd_valid = 1 with data in N+1. Back-to-back reads give one result per cycle. rd_rgb holds its last value while rd_valid = 0.
- Write-to-read: a write to the back bank in cycle N is visible to reads issued from cycle N+1 onward, once that bank is front.
- Swap: frame_end in cycle N (swap conditions met) → front toggles at the end of N. Reads issued in N+1 use the new bank. swap_done is high in N+1.
- Clear: clear_req in cycle N → clr_busy high in N+1 through N+1024, low in N+1025. wr_ready is the inverse of clr_busy. Exactly 1024 clear writes.
- clear_req and frame_end with a pending swap in the same cycle: the swap executes first (clr_busy is still 0), then the clear starts on the new back bank.

## Configuration
- MATRIX_FB_CLEAR_EN:
  - Defined: the clear FSM and clr_addr counter are built as described above.
  - Undefined: clear_req is ignored, clr_busy is tied to 0, wr_ready is tied to 1, and the swap condition ignores clr_busy.

## Test plan
- Reset, then rd_en at (0,0) → rd_valid in the next cycle; all outputs hold their reset values until then.
- Write 3'b100 to (x=5, y=3) and 3'b010 to (x=5, y=19), then swap_req and frame_end → swap_done one cycle later. A read at row 3, col 5 returns rd_rgb0 = 3'b100, rd_rgb1 = 3'b010.
- swap_req with no frame_end for 100 cycles → front unchanged and reads return old data. First frame_end → swap; swap_done pulses exactly once.
- Write 3'b111 in the same cycle as the swap edge → the pixel is readable from the new front bank.
- (MATRIX_FB_CLEAR_EN) Fill the back bank with 3'b111, clear_req → clr_busy high for 1024 cycles and writes during that window are dropped. After swap, every address reads 0.
- (MATRIX_FB_CLEAR_EN) swap_req plus frame_end during a clear → no swap. The first frame_end after clr_busy falls → swap executes and swap_done pulses.
